acq_capture: RTL and testbench

ACQ_CAPTURE -- requirements
Module: acq_capture

---
 rtl/acq_capture_if.sv | 32 +++
 rtl/acq_capture.sv | 160 ++++++++++++++++
 tb/tb_acq_capture.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/acq_capture_if.sv
// Control, ADC sample and acquisition-buffer write bus for acq_capture.
// pretrig carries one extra bit so out-of-range counts can be requested and clamped.
interface acq_capture_if #(
  parameter int unsigned ADDRWIDTH = 12,
  parameter int unsigned DATAWIDTH = 64,
  parameter int unsigned DECW      = 8
);
  logic                 stb_arm;
  logic                 stb_abort;
  logic                 trig;
  logic [ADDRWIDTH:0]   pretrig;
  logic [DECW-1:0]      decim;
  logic [DATAWIDTH-1:0] adc0;
  logic [DATAWIDTH-1:0] adc1;
  logic [DATAWIDTH-1:0] data_acqbuf0;
  logic [DATAWIDTH-1:0] data_acqbuf1;
  logic [ADDRWIDTH-1:0] addr_acqbuf;
  logic                 we_acqbuf;
  logic                 busy;
  logic                 done;
  logic [ADDRWIDTH-1:0] trig_addr;

  modport master (
    output stb_arm, stb_abort, trig, pretrig, decim, adc0, adc1,
    input  data_acqbuf0, data_acqbuf1, addr_acqbuf, we_acqbuf, busy, done, trig_addr
  );

  modport slave (
    input  stb_arm, stb_abort, trig, pretrig, decim, adc0, adc1,
    output data_acqbuf0, data_acqbuf1, addr_acqbuf, we_acqbuf, busy, done, trig_addr
  );
endinterface

// File: rtl/acq_capture.sv
// Triggered ring-buffer acquisition: writes decimated ADC samples into a circular buffer,
// keeping P pre-trigger samples and D-P post-trigger samples. Writes leave through a
// two-stage pipeline, so a sample ticked in cycle T is written in cycle T+2.
module acq_capture #(
  parameter int unsigned ADDRWIDTH = 12,
  parameter int unsigned DATAWIDTH = 64,
  parameter int unsigned DECW      = 8
) (
  input logic          clk,
  input logic          reset,
  acq_capture_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StDone} state_e;

  state_e               state_q;
  logic [DECW-1:0]      dcnt_q;
  logic [DECW-1:0]      decim_q;
  logic [ADDRWIDTH-1:0] p_q;
  logic [ADDRWIDTH-1:0] cnt_q;
  logic [ADDRWIDTH-1:0] wr_addr_q;
  logic [ADDRWIDTH-1:0] trig_addr_q;
  logic                 busy_q;
  logic                 done_q;

  // Write pipeline: stage 1 captures the ticked sample, stage 2 drives the buffer ports.
  logic                 s1_we_q;
  logic [ADDRWIDTH-1:0] s1_addr_q;
  logic [DATAWIDTH-1:0] s1_d0_q;
  logic [DATAWIDTH-1:0] s1_d1_q;
  logic                 we_q;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0] d0_q;
  logic [DATAWIDTH-1:0] d1_q;

  logic                 tick;
  logic                 capturing;
  logic                 wr;
  logic [ADDRWIDTH-1:0] p_clamped;

  // Decode the write tick and clamp the requested pre-trigger count to D-1.
  always_comb begin
    p_clamped = bus.pretrig[ADDRWIDTH] ? {ADDRWIDTH{1'b1}} : bus.pretrig[ADDRWIDTH-1:0];
    tick      = (dcnt_q == '0);
    capturing = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
    // A strobe cycle restarts or cancels the capture, so it never issues a write itself.
    wr        = capturing && tick && !bus.stb_arm && !bus.stb_abort;
  end

  // Capture FSM with its counters, address, trigger address and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      dcnt_q      <= '0;
      decim_q     <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus.stb_abort) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.stb_arm) begin
      p_q       <= p_clamped;
      decim_q   <= bus.decim;
      dcnt_q    <= '0;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      state_q   <= (p_clamped != '0) ? StPre : StWait;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      if (capturing) begin
        dcnt_q <= tick ? decim_q : dcnt_q - 1'b1;
      end
      if (wr) begin
        wr_addr_q <= wr_addr_q + 1'b1;
      end
      unique case (state_q)
        StPre: begin
          if (wr) begin
            if (cnt_q == p_q - 1'b1) begin
              cnt_q   <= '0;
              state_q <= StWait;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StWait: begin
          if (bus.trig) begin
            // The next write address is the current one whether or not this cycle ticks.
            trig_addr_q <= wr_addr_q;
            // A tick in the trigger cycle is already the first post-trigger write.
            // ~p_q equals D-1-P, the index of the last post-trigger write.
            if (wr && (p_q == {ADDRWIDTH{1'b1}})) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q   <= wr ? {{(ADDRWIDTH-1){1'b0}}, 1'b1} : '0;
              state_q <= StPost;
            end
          end
        end
        StPost: begin
          if (wr) begin
            if (cnt_q == ~p_q) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Two-cycle write pipeline; already-issued writes drain even after an abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_we_q   <= 1'b0;
      s1_addr_q <= '0;
      s1_d0_q   <= '0;
      s1_d1_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
    end else begin
      s1_we_q <= wr;
      if (wr) begin
        s1_addr_q <= wr_addr_q;
        s1_d0_q   <= bus.adc0;
        s1_d1_q   <= bus.adc1;
      end
      we_q <= s1_we_q;
      if (s1_we_q) begin
        addr_q <= s1_addr_q;
        d0_q   <= s1_d0_q;
        d1_q   <= s1_d1_q;
      end
    end
  end

  assign bus.we_acqbuf    = we_q;
  assign bus.addr_acqbuf  = addr_q;
  assign bus.data_acqbuf0 = d0_q;
  assign bus.data_acqbuf1 = d1_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.trig_addr    = trig_addr_q;

endmodule

// File: tb/tb_acq_capture.sv
// Scoreboard bench for acq_capture with a 16-entry buffer.
module tb_acq_capture;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned DCW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  acq_capture_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .DECW(DCW)) bus ();

  acq_capture #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .DECW(DCW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] mem[16];
  logic [DW-1:0] cyc;
  logic [DW-1:0] arm_cyc;
  logic [AW-1:0] exp_addr;

  function automatic logic [DW-1:0] adc1_of(input logic [DW-1:0] c);
    return c ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every buffer write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.we_acqbuf === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got write at addr %0d expected none", bus.addr_acqbuf);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", DW'(bus.addr_acqbuf), DW'(mon_e.addr));
        check("wr_data0", bus.data_acqbuf0, mon_e.d0);
        check("wr_data1", bus.data_acqbuf1, mon_e.d1);
      end
      mem[bus.addr_acqbuf] = bus.data_acqbuf0;
    end
  end

  // One cycle of stimulus; wexp queues the write this cycle's sample must produce.
  task automatic drive(input logic arm, input logic abort, input logic trg, input logic wexp);
    exp_t e;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    bus.adc0 = cyc;
    bus.adc1 = adc1_of(cyc);
    bus.stb_arm = arm;
    bus.stb_abort = abort;
    bus.trig = trg;
    if (arm && !abort) begin
      exp_addr = '0;
      arm_cyc = cyc;
    end
    if (wexp) begin
      e.addr = exp_addr;
      e.d0 = cyc;
      e.d1 = adc1_of(cyc);
      sb.push_back(e);
      exp_addr = exp_addr + 1'b1;
    end
  endtask

  // Arm, run a full capture of nwr writes (ticks at offsets 1, 1+(dec+1), ...), check status.
  task automatic capture(input string name, input logic [AW:0] p, input logic [DCW-1:0] dec,
                         input int trig_on, input int trig_off, input int nwr,
                         input logic [AW-1:0] exp_taddr);
    int last;
    last = 1 + (nwr - 1) * (int'(dec) + 1);
    bus.pretrig = p;
    bus.decim = dec;
    drive(1'b1, 1'b0, trig_on == 0, 1'b0);
    for (int off = 1; off <= last + 2; off++) begin
      drive(1'b0, 1'b0, (off >= trig_on) && (off < trig_off),
            (off <= last) && (((off - 1) % (int'(dec) + 1)) == 0));
      if (off == 1) check({name, "_busy"}, DW'(bus.busy), 1);
      if (off == last) check({name, "_done_early"}, DW'(bus.done), 0);
      if (off == last + 1) begin
        check({name, "_done"}, DW'(bus.done), 1);
        check({name, "_busy_end"}, DW'(bus.busy), 0);
      end
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check({name, "_trig_addr"}, DW'(bus.trig_addr), DW'(exp_taddr));
    check({name, "_done_held"}, DW'(bus.done), 1);
    check({name, "_drained"}, DW'(sb.size()), 0);
  endtask

  initial begin
    bus.stb_arm = 1'b0;
    bus.stb_abort = 1'b0;
    bus.trig = 1'b0;
    bus.pretrig = '0;
    bus.decim = '0;
    bus.adc0 = '0;
    bus.adc1 = '0;
    cyc = '0;
    arm_cyc = '0;
    exp_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", DW'(bus.busy), 0);
    check("rst_done", DW'(bus.done), 0);
    check("rst_we", DW'(bus.we_acqbuf), 0);
    check("rst_addr", DW'(bus.addr_acqbuf), 0);
    check("rst_trig_addr", DW'(bus.trig_addr), 0);
    check("rst_data0", bus.data_acqbuf0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Idle ignores trig.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_busy", DW'(bus.busy), 0);

    // P=4, trig pulse 10 cycles after arm: WAIT writes addr 4..8, trigger writes addr 9.
    capture("t_basic", 4, 0, 10, 11, 21, 4'd9);
    // Buffer reads as 16 consecutive samples starting 4 before trig_addr.
    for (int k = 0; k < 16; k++) check("t_basic_buf", mem[(5 + k) % 16], arm_cyc + 6 + k);

    // decim=3, P=0, trig high from arm: 16 writes every 4th cycle, addresses 0..15.
    capture("t_decim", 0, 3, 0, 1000, 16, 4'd0);

    // P=20 clamps to 15: 15 pre writes ignore trig, then exactly one post write at addr 15.
    capture("t_clamp", 20, 0, 0, 1000, 16, 4'd15);

    // 40 WAIT ticks wrap the ring; trigger then lands on addr 8.
    capture("t_wrap", 0, 0, 41, 42, 56, 4'd8);

    // Abort from DONE clears done and keeps trig_addr.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("t_abort_done", DW'(bus.done), 0);
    check("t_abort_taddr", DW'(bus.trig_addr), 8);

    // Arm+abort together mid-POST: abort wins, issued writes drain, nothing after.
    bus.pretrig = 0;
    bus.decim = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int off = 1; off <= 4; off++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("t_armabort_busy", DW'(bus.busy), 0);
    check("t_armabort_done", DW'(bus.done), 0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("t_armabort_drained", DW'(sb.size()), 0);

    // Re-arm mid-POST with P=2: restart from addr 0, trigger at addr 2.
    bus.pretrig = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int off = 1; off <= 4; off++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    bus.pretrig = 2;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int off = 6; off <= 23; off++) begin
      drive(1'b0, 1'b0, off >= 8, off <= 21);
      if (off == 21) check("t_rearm_done_early", DW'(bus.done), 0);
      if (off == 22) check("t_rearm_done", DW'(bus.done), 1);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("t_rearm_trig_addr", DW'(bus.trig_addr), 2);
    check("t_rearm_drained", DW'(sb.size()), 0);

    // Reset pulse mid-POST: outputs clear at once, in-flight writes are dropped.
    bus.pretrig = 2;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int off = 1; off <= 5; off++) drive(1'b0, 1'b0, 1'b1, off <= 3);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("t_rst_we", DW'(bus.we_acqbuf), 0);
    check("t_rst_addr", DW'(bus.addr_acqbuf), 0);
    check("t_rst_data0", bus.data_acqbuf0, 0);
    check("t_rst_data1", bus.data_acqbuf1, 0);
    check("t_rst_busy", DW'(bus.busy), 0);
    check("t_rst_done", DW'(bus.done), 0);
    check("t_rst_trig_addr", DW'(bus.trig_addr), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("t_rst_idle_busy", DW'(bus.busy), 0);
    check("t_rst_drained", DW'(sb.size()), 0);

    // Capture works normally after reset.
    capture("t_after_rst", 0, 0, 0, 1000, 16, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
